// File: rtl/iob_psplit.sv
// IOb address-decoded splitter: one master to N_SLAVES slaves, in-order reads.
// Optional read-timeout / orphan-drop logic under IOB_PSPLIT_TIMEOUT_EN.
module iob_psplit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_W = 2,
  parameter int P_SLAVES = ADDR_W - 3,
  parameter int DEPTH = 4,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hBADADD00),
  parameter int TIMEOUT_CYCLES = 255,
  localparam int REQ_W = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W = DATA_W + 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       cke_i,
  input  logic [REQ_W-1:0]           m_req_i,
  output logic [RESP_W-1:0]          m_resp_o,
  output logic [N_SLAVES*REQ_W-1:0]  s_req_o,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = SEL_W + 1;

  logic              avalid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  assign {avalid, addr, wdata, wstrb} = m_req_i;

  logic [SEL_W-1:0] sel;
  logic             dec_err;
  logic             is_read;
  logic [TAG_W-1:0] tag;

  assign sel = addr[P_SLAVES -: SEL_W];
  assign dec_err = 32'(sel) >= N_SLAVES;
  assign is_read = (wstrb == '0);
  // all decode errors share one tag so they may queue back to back
  assign tag = dec_err ? {1'b1, SEL_W'(0)} : {1'b0, sel};

  logic [N_SLAVES-1:0] s_ready;
  logic [N_SLAVES-1:0] s_rvalid;
  logic [DATA_W-1:0]   s_rdata [N_SLAVES];
  logic [N_SLAVES-1:0] s_avalid;

  logic             stall;

  for (genvar k = 0; k < N_SLAVES; k++) begin : g_s
    assign s_ready[k] = s_resp_i[k*RESP_W];
    assign s_rvalid[k] = s_resp_i[k*RESP_W+1];
    assign s_rdata[k] = s_resp_i[k*RESP_W+2 +: DATA_W];
    assign s_avalid[k] = rst_n_i & avalid & ~stall & ~dec_err
                       & (sel == SEL_W'(k));
    assign s_req_o[k*REQ_W +: REQ_W] = {s_avalid[k], addr, wdata, wstrb};
  end

  logic [TAG_W-1:0] fifo [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W-1:0] wp_last;
  logic [CNT_W-1:0] cnt;
  logic             empty;
  logic             full;
  logic [TAG_W-1:0] head;
  logic             head_err;
  logic [SEL_W-1:0] head_sel;

  assign empty = (cnt == '0);
  assign full = (cnt == CNT_W'(DEPTH));
  assign wp_last = wp - PTR_W'(1);
  assign head = fifo[rp];
  assign head_err = head[SEL_W];
  assign head_sel = head[SEL_W-1:0];

  // reads wait while the queue is full or targets a different slave
  assign stall = avalid & is_read
               & (full | (~empty & (tag != fifo[wp_last])));

  logic              sel_ready;
  logic              hd_rvalid;
  logic [DATA_W-1:0] hd_rdata;
  logic              resp_ok;
  logic              err_pop;
  logic              timeout;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              push;
  logic              pop;

`ifdef IOB_PSPLIT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]     to_cnt;
  logic [N_SLAVES-1:0] orphan;
  logic [N_SLAVES-1:0] orph_set;
  logic [N_SLAVES-1:0] orph_clr;
  logic                hd_orph;

  // pick selected-slave ready and head-slave response
  always_comb begin
    sel_ready = 1'b0;
    hd_rvalid = 1'b0;
    hd_rdata = '0;
    hd_orph = 1'b0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel == SEL_W'(k)) sel_ready = s_ready[k];
      if (head_sel == SEL_W'(k)) begin
        hd_rvalid = s_rvalid[k];
        hd_rdata = s_rdata[k];
        hd_orph = orphan[k];
      end
    end
  end

  assign resp_ok = ~empty & ~head_err & hd_rvalid & ~hd_orph;
  assign timeout = ~empty & ~head_err & ~resp_ok
                 & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // stale responses from timed-out slaves are swallowed once
  always_comb begin
    orph_set = '0;
    orph_clr = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      orph_set[k] = timeout & (head_sel == SEL_W'(k));
      orph_clr[k] = orphan[k] & s_rvalid[k];
    end
  end

  // head-wait counter and orphan flags
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      to_cnt <= '0;
      orphan <= '0;
    end else if (cke_i) begin
      if (pop || empty) to_cnt <= '0;
      else to_cnt <= to_cnt + TO_W'(1);
      orphan <= (orphan & ~orph_clr) | orph_set;
    end
  end
`else
  // pick selected-slave ready and head-slave response
  always_comb begin
    sel_ready = 1'b0;
    hd_rvalid = 1'b0;
    hd_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel == SEL_W'(k)) sel_ready = s_ready[k];
      if (head_sel == SEL_W'(k)) begin
        hd_rvalid = s_rvalid[k];
        hd_rdata = s_rdata[k];
      end
    end
  end

  assign resp_ok = ~empty & ~head_err & hd_rvalid;
  assign timeout = 1'b0;
`endif

  assign err_pop = ~empty & head_err;
  assign ready = rst_n_i & ~stall & (dec_err | sel_ready);
  assign rvalid = rst_n_i & (resp_ok | err_pop | timeout);
  assign rdata = !rst_n_i ? '0
               : (err_pop | timeout) ? ERR_DATA
               : resp_ok ? hd_rdata : '0;
  assign m_resp_o = {rdata, rvalid, ready};

  assign push = avalid & ready & is_read;
  assign pop = rvalid;

  // tag storage, written only on an accepted read
  always_ff @(posedge clk_i) begin
    if (cke_i && push) fifo[wp] <= tag;
  end

  // queue pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (cke_i) begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop) rp <= rp + PTR_W'(1);
      if (push && !pop) cnt <= cnt + CNT_W'(1);
      else if (!push && pop) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_iob_psplit.sv
// Bench for iob_psplit: decode table plus scoreboarded read sequences.
// Define IOB_PSPLIT_TIMEOUT_EN to also exercise the timeout path.
module tb_iob_psplit;

  localparam int RQ = 69;
  localparam int RS = 34;
  localparam logic [31:0] ERRD = 32'hBADADD00;
`ifdef IOB_PSPLIT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk;
  logic          rst_n;
  logic          cke;
  logic          m_av;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;
  logic [RQ-1:0] m_req;
  logic [RS-1:0] m_resp;
  logic [3*RQ-1:0] s_req;
  logic [3*RS-1:0] s_resp;
  logic [2:0]    sr_ready;
  logic [2:0]    sr_rvalid;
  logic [31:0]   sr_rdata [3];

  int tests = 0;
  int fails = 0;
  logic [31:0] sbq [$];
  logic [31:0] exp_rd;

  assign m_req = {m_av, m_addr, m_wdata, m_wstrb};

  always_comb begin
    s_resp = '0;
    for (int k = 0; k < 3; k++)
      s_resp[k*RS +: RS] = {sr_rdata[k], sr_rvalid[k], sr_ready[k]};
  end

  iob_psplit #(
    .ADDR_W(32), .DATA_W(32), .N_SLAVES(3), .SEL_W(2),
    .P_SLAVES(29), .DEPTH(4), .ERR_DATA(ERRD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke),
    .m_req_i(m_req), .m_resp_o(m_resp),
    .s_req_o(s_req), .s_resp_i(s_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] avm();
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = s_req[k*RQ + RQ - 1];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [31:0] a,
                       input logic [3:0] ws);
    m_av = av;
    m_addr = a;
    m_wdata = a ^ 32'h5A5A_0000;
    m_wstrb = ws;
  endtask

  task automatic resp(input int k, input logic [31:0] d);
    sr_rvalid = '0;
    sr_rvalid[k] = 1'b1;
    sr_rdata[k] = d;
  endtask

  // scoreboard: every master rvalid must match the oldest expected read
  always @(negedge clk) begin
    if (rst_n && m_resp[1]) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL rvalid_unexpected: got rdata %h required none",
                 m_resp[33:2]);
      end else begin
        exp_rd = sbq.pop_front();
        if (m_resp[33:2] !== exp_rd) begin
          fails++;
          $display("FAIL rdata: got %h required %h", m_resp[33:2], exp_rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        av;
    logic [31:0] addr;
    logic [3:0]  ws;
    logic [2:0]  rdy;
    logic [2:0]  e_av;
    logic        e_rdy;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 32'h1000_0004, 4'h0, 3'b111, 3'b010, 1'b1};
    tbl[1] = '{1'b1, 32'h0000_0010, 4'h0, 3'b111, 3'b001, 1'b1};
    tbl[2] = '{1'b1, 32'h2000_0000, 4'hF, 3'b011, 3'b100, 1'b0};
    tbl[3] = '{1'b1, 32'h3000_0000, 4'h0, 3'b000, 3'b000, 1'b1};
    tbl[4] = '{1'b1, 32'h3000_0000, 4'hF, 3'b000, 3'b000, 1'b1};
    tbl[5] = '{1'b1, 32'hD000_0000, 4'h0, 3'b101, 3'b010, 1'b0};
    tbl[6] = '{1'b1, 32'h4000_0000, 4'h0, 3'b001, 3'b001, 1'b1};
    tbl[7] = '{1'b0, 32'h1000_0000, 4'h0, 3'b111, 3'b000, 1'b1};

    rst_n = 1'b0;
    cke = 1'b1;
    sr_ready = 3'b111;
    sr_rvalid = 3'b111;
    for (int k = 0; k < 3; k++) sr_rdata[k] = 32'hFFFF_0000 + k;
    drive(1'b1, 32'h1000_0004, 4'h0);
    tick();
    tick();
    #2;
    chk("rst_avalid", avm(), 3'b000);
    chk("rst_ready", m_resp[0], 1'b0);
    chk("rst_rvalid", m_resp[1], 1'b0);
    chk("rst_rdata", m_resp[33:2], 32'h0);
    drive(1'b0, 32'h0, 4'h0);
    sr_rvalid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // decode table, state frozen by cke low
    cke = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].av, tbl[i].addr, tbl[i].ws);
      sr_ready = tbl[i].rdy;
      #2;
      chk($sformatf("tbl%0d_avalid", i), avm(), tbl[i].e_av);
      chk($sformatf("tbl%0d_ready", i), m_resp[0], tbl[i].e_rdy);
      chk($sformatf("tbl%0d_bcast", i), s_req[2*RQ +: RQ-1], m_req[RQ-2:0]);
      tick();
    end
    drive(1'b0, 32'h0, 4'h0);
    sr_ready = 3'b111;
    tick();
    cke = 1'b1;
    tick();

    // single read to slave 1, answered two cycles later
    drive(1'b1, 32'h1000_0004, 4'h0);
    #2;
    chk("a_avalid", avm(), 3'b010);
    chk("a_ready", m_resp[0], 1'b1);
    sbq.push_back(32'h1234);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    tick();
    resp(1, 32'h1234);
    #2;
    chk("a_rvalid", m_resp[1], 1'b1);
    tick();
    sr_rvalid = '0;
    #2;
    chk("a_sb_empty", sbq.size(), 0);
    tick();

    // decode-error read, then decode-error write
    drive(1'b1, 32'h3000_0000, 4'h0);
    #2;
    chk("b_ready", m_resp[0], 1'b1);
    chk("b_avalid", avm(), 3'b000);
    sbq.push_back(ERRD);
    tick();
    drive(1'b1, 32'h3000_0000, 4'hF);
    #2;
    chk("b_err_rvalid", m_resp[1], 1'b1);
    chk("b_wr_avalid", avm(), 3'b000);
    chk("b_wr_ready", m_resp[0], 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    #2;
    chk("b_rvalid_off", m_resp[1], 1'b0);
    tick();

    // five reads to a silent slave 2
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h2000_0000 + 32'(4 * i), 4'h0);
      #2;
      chk($sformatf("c_rd%0d_ready", i), m_resp[0], i < 4);
      chk($sformatf("c_rd%0d_avalid", i), avm(), i < 4 ? 3'b100 : 3'b000);
      if (i < 4) sbq.push_back(32'hC0 + 32'(i));
      tick();
    end
    #2;
    chk("c_still_stall", m_resp[0], 1'b0);
    tick();
    resp(2, 32'hC0);
    #2;
    chk("c_pop_cycle_stall", m_resp[0], 1'b0);
    tick();
    sr_rvalid = '0;
    #2;
    chk("c_rd4_ready", m_resp[0], 1'b1);
    sbq.push_back(32'hC4);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    for (int i = 1; i < 5; i++) begin
      resp(2, 32'hC0 + 32'(i));
      tick();
    end
    sr_rvalid = '0;
    #2;
    chk("c_sb_empty", sbq.size(), 0);
    tick();

    // slave 0 pending blocks a slave 1 read but not a slave 1 write
    drive(1'b1, 32'h0000_0100, 4'h0);
    sbq.push_back(32'hD0);
    tick();
    drive(1'b1, 32'h1000_0100, 4'h0);
    #2;
    chk("d_rd1_avalid", avm(), 3'b000);
    chk("d_rd1_ready", m_resp[0], 1'b0);
    tick();
    drive(1'b1, 32'h1000_0200, 4'hF);
    resp(1, 32'hEE);
    #2;
    chk("d_wr1_avalid", avm(), 3'b010);
    chk("d_wr1_ready", m_resp[0], 1'b1);
    chk("d_nonhead_rvalid", m_resp[1], 1'b0);
    tick();
    sr_rvalid = '0;
    drive(1'b1, 32'h1000_0100, 4'h0);
    resp(0, 32'hD0);
    #2;
    chk("d_rd1_hold", avm(), 3'b000);
    tick();
    sr_rvalid = '0;
    #2;
    chk("d_rd1_go", avm(), 3'b010);
    sbq.push_back(32'hD1);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    tick();
    resp(1, 32'hD1);
    tick();
    sr_rvalid = '0;
    #2;
    chk("d_sb_empty", sbq.size(), 0);
    tick();

    // reset with three reads outstanding
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_0000 + 32'(4 * i), 4'h0);
      #2;
      chk($sformatf("e_rd%0d_ready", i), m_resp[0], 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 4'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    resp(0, 32'h55);
    drive(1'b1, 32'h1000_0000, 4'h0);
    #2;
    chk("e_late_rvalid", m_resp[1], 1'b0);
    chk("e_rd_s1_ready", m_resp[0], 1'b1);
    sbq.push_back(32'h77);
    tick();
    sr_rvalid = '0;
    drive(1'b0, 32'h0, 4'h0);
    tick();
    resp(1, 32'h77);
    tick();
    sr_rvalid = '0;
    #2;
    chk("e_sb_empty", sbq.size(), 0);
    tick();

`ifdef IOB_PSPLIT_TIMEOUT_EN
    // silent slave 0 times out, its late answer is dropped
    drive(1'b1, 32'h0000_0040, 4'h0);
    sbq.push_back(ERRD);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    for (int c = 1; c < TO; c++) begin
      #2;
      chk($sformatf("f_wait%0d", c), m_resp[1], 1'b0);
      tick();
    end
    #2;
    chk("f_timeout_rvalid", m_resp[1], 1'b1);
    chk("f_timeout_rdata", m_resp[33:2], ERRD);
    tick();
    tick();
    resp(0, 32'h99);
    #2;
    chk("f_orphan_drop", m_resp[1], 1'b0);
    tick();
    sr_rvalid = '0;
    drive(1'b1, 32'h0000_0044, 4'h0);
    sbq.push_back(32'hAB);
    tick();
    drive(1'b0, 32'h0, 4'h0);
    resp(0, 32'hAB);
    #2;
    chk("f_after_orphan", m_resp[1], 1'b1);
    tick();
    sr_rvalid = '0;
    tick();
`endif

    #2;
    chk("final_sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iob_psplit.md
IOB_PSPLIT -- requirements
Module: iob_psplit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, IOb address width.
REQ-002 SHALL have parameter DATA_W, default 32, IOb data width; REQ_W=1+ADDR_W+DATA_W+DATA_W/8, RESP_W=DATA_W+2.
REQ-003 SHALL have parameter N_SLAVES, default 4, slave count, 1..16, any value.
REQ-004 SHALL have parameter SEL_W, default 2, select field width, 2^SEL_W >= N_SLAVES.
REQ-005 SHALL have parameter P_SLAVES, default ADDR_W-3, MSB bit position of select field addr[P_SLAVES -: SEL_W].
REQ-006 SHALL have parameter DEPTH, default 4, outstanding-read tracking depth, power of 2 >= 2.
REQ-007 SHALL have parameter ERR_DATA, default 32'hBADADD00, rdata returned on decode error or timeout.
REQ-008 SHALL have parameter TIMEOUT_CYCLES, default 255, read-response timeout.
REQ-009 clk_i  input  1  system clock, all logic rising-edge.
REQ-010 rst_n_i  input  1  reset, synchronous, active-low.
REQ-011 cke_i  input  1  clock enable; low freezes all state.
REQ-012 m_req_i  input  REQ_W  master request {avalid, addr, wdata, wstrb}; wstrb==0 is read.
REQ-013 m_resp_o  output  RESP_W  master response {rdata, rvalid, ready}.
REQ-014 s_req_o  output  N_SLAVES*REQ_W  per-slave request, slave k at bits [k*REQ_W +: REQ_W].
REQ-015 s_resp_i  input  N_SLAVES*RESP_W  per-slave response, slave k at bits [k*RESP_W +: RESP_W].

Function
REQ-016 SHALL decode sel = addr[P_SLAVES -: SEL_W]; sel >= N_SLAVES is a decode error.
REQ-017 SHALL broadcast addr/wdata/wstrb to all slaves; only slave sel gets avalid = m avalid & ~stall; zero added request latency.
REQ-018 m ready SHALL equal ready of slave sel & ~stall; on decode error, ready=1 & ~stall.
REQ-019 Accepted read (avalid & ready & wstrb==0) SHALL push sel (or ERR tag) into a DEPTH-entry FIFO; writes push nothing.
REQ-020 stall SHALL assert for reads when FIFO full, or FIFO non-empty and sel differs from last pushed tag; writes never stall.
REQ-021 m rvalid/rdata SHALL come combinationally from the FIFO-head slave; pop on that rvalid; rvalid from non-head slaves ignored.
REQ-022 ERR head SHALL produce rvalid with rdata=ERR_DATA one cycle after becoming head, then pop; decode-error writes discarded.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo DEPTH.
REQ-024 Same-cycle accept of read and its own response SHALL NOT occur (push visible next cycle).

Reset
REQ-025 rst_n_i low at a clock edge SHALL empty the FIFO, clear pointers, counters and orphan flags, mid-transaction included.
REQ-026 While rst_n_i low, all slave avalid, m rvalid and m ready SHALL be 0; m rdata 0.

Configuration
REQ-027 With IOB_PSPLIT_TIMEOUT_EN defined, a head-wait counter SHALL count cycles non-empty without head response, clearing on pop.
REQ-028 On count reaching TIMEOUT_CYCLES SHALL emit rvalid with rdata=ERR_DATA, pop, set orphan flag of that slave.
REQ-029 Next rvalid from a slave with orphan set SHALL be dropped and clear the flag.
REQ-030 Without IOB_PSPLIT_TIMEOUT_EN, counter and orphan logic SHALL be absent; head waits indefinitely.

Verification (N_SLAVES=3, SEL_W=2, P_SLAVES=29, DEPTH=4)
REQ-031 Read addr 0x1000_0004, slave 1 rvalid rdata 0x1234 after 2 cycles -> only s1 avalid, m rdata 0x1234, FIFO empty.
REQ-032 Read 0x3000_0000 (sel=3) -> ready same cycle, next cycle rvalid rdata 0xBADADD00; write same addr -> no slave avalid.
REQ-033 5 back-to-back reads to slave 2, slave never responds -> 4 accepted, 5th stalled until first pop.
REQ-034 Read slave 0 pending then read slave 1 -> slave 1 avalid held 0 until slave 0 rvalid; write slave 1 meanwhile passes.
REQ-035 rst_n_i low 1 cycle with 3 reads outstanding -> FIFO empty, late slave rvalid not forwarded.
REQ-036 TIMEOUT_EN, TIMEOUT_CYCLES=8, slave 0 silent -> rvalid ERR_DATA at cycle 8; later slave 0 rvalid dropped.
